// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine, one bit per cycle beside the EX ALU.
// Optional MULDIV_EARLY_OUT_EN adds 1-iteration zero-multiply / small-dividend exits.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_e;

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  hi_q, hi_d;
   logic [XLEN-1:0]  lo_q, lo_d;
   logic [XLEN-1:0]  opd_q, opd_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic [2:0]       op_q, op_d;
   logic [4:0]       rdp_q, rdp_d;
   logic [4:0]       rd_q, rd_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             fast_q, fast_d;
   logic             valid_q, valid_d;

   logic            is_div, sgn1, sgn2, s1, s2;
   logic [XLEN-1:0] mag1, mag2;
   logic            div0, ovf, early;

   // Operand decode for the op being offered this cycle
   always_comb begin
      is_div = op_i[2];
      sgn1   = (op_i != 3'd3) && (op_i != 3'd5)
               && (op_i != 3'd7);
      sgn2   = (op_i == 3'd0) || (op_i == 3'd1)
               || (op_i == 3'd4) || (op_i == 3'd6);
      s1     = sgn1 & rs1_i[XLEN-1];
      s2     = sgn2 & rs2_i[XLEN-1];
      mag1   = s1 ? -rs1_i : rs1_i;
      mag2   = s2 ? -rs2_i : rs2_i;
      div0   = is_div & (rs2_i == '0);
      ovf    = is_div & ~op_i[0] & (rs1_i == SMIN)
               & (rs2_i == '1);
`ifdef MULDIV_EARLY_OUT_EN
      early  = is_div ? (mag2 > mag1)
                      : ((rs1_i == '0) | (rs2_i == '0));
`else
      early  = 1'b0;
`endif
   end

   logic [XLEN:0]     msum, dshf, ddif;
   logic [XLEN-1:0]   st_hi, st_lo;
   logic [2*XLEN-1:0] raw, prod;
   logic [XLEN-1:0]   quo, rem, fmt;

   // One iteration step plus final sign correction
   always_comb begin
      msum  = {1'b0, hi_q}
              + {1'b0, (lo_q[0] ? opd_q : {XLEN{1'b0}})};
      dshf  = {hi_q, lo_q[XLEN-1]};
      ddif  = dshf - {1'b0, opd_q};
      st_hi = hi_q;
      st_lo = lo_q;
      if (!fast_q) begin
         if (state_q == S_DIV) begin
            st_lo = {lo_q[XLEN-2:0], ~ddif[XLEN]};
            st_hi = ddif[XLEN] ? dshf[XLEN-1:0]
                               : ddif[XLEN-1:0];
         end else begin
            st_hi = msum[XLEN:1];
            st_lo = {msum[0], lo_q[XLEN-1:1]};
         end
      end
      raw  = {st_hi, st_lo};
      prod = qneg_q ? -raw : raw;
      quo  = qneg_q ? -st_lo : st_lo;
      rem  = rneg_q ? -st_hi : st_hi;
      unique case (op_q)
         3'd0:             fmt = prod[XLEN-1:0];
         3'd1, 3'd2, 3'd3: fmt = prod[2*XLEN-1:XLEN];
         3'd4, 3'd5:       fmt = quo;
         default:          fmt = rem;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opd_d    = opd_q;
      op_d     = op_q;
      rdp_d    = rdp_q;
      rd_d     = rd_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      fast_d   = fast_q;
      result_d = result_q;
      valid_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i && !flush_i) begin
               op_d   = op_i;
               rdp_d  = rd_i;
               cnt_d  = CNT_INIT;
               fast_d = div0 | ovf | early;
               qneg_d = s1 ^ s2;
               rneg_d = s1;
               opd_d  = is_div ? mag2 : mag1;
               hi_d   = '0;
               lo_d   = is_div ? mag1 : mag2;
               // Fast paths preload the final raw result
               if (div0) begin
                  hi_d   = rs1_i;
                  lo_d   = '1;
                  qneg_d = 1'b0;
                  rneg_d = 1'b0;
               end else if (ovf) begin
                  hi_d   = '0;
                  lo_d   = rs1_i;
                  qneg_d = 1'b0;
                  rneg_d = 1'b0;
               end else if (early) begin
                  hi_d   = is_div ? rs1_i : '0;
                  lo_d   = '0;
                  qneg_d = 1'b0;
                  rneg_d = 1'b0;
               end
               state_d = is_div ? S_DIV : S_MUL;
            end
         end
         S_MUL, S_DIV: begin
            hi_d  = st_hi;
            lo_d  = st_lo;
            cnt_d = cnt_q - CNT_ONE;
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (fast_q || cnt_q == CNT_ONE) begin
               state_d  = S_DONE;
               valid_d  = 1'b1;
               result_d = fmt;
               rd_d     = rdp_q;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opd_q    <= '0;
         op_q     <= '0;
         rdp_q    <= '0;
         rd_q     <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         fast_q   <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opd_q    <= opd_d;
         op_q     <= op_d;
         rdp_q    <= rdp_d;
         rd_q     <= rd_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         fast_q   <= fast_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign busy_o   = (state_q == S_MUL) || (state_q == S_DIV);
   assign stall_o  = ((state_q == S_IDLE) & start_i & ~flush_i)
                     | busy_o;
   assign valid_o  = valid_q & ~flush_i;
   assign result_o = result_q;
   assign rd_o     = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (XLEN=32).
// Expected latencies of early-out cases follow MULDIV_EARLY_OUT_EN.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic [4:0]  rd = '0;
   logic        flush = 1'b0;
   logic        stall, busy, valid;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int n_chk = 0;
   int n_pass = 0;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int EO_LAT = 1;
`else
   localparam int EO_LAT = 32;
`endif

   muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .op_i     (op),
      .rs1_i    (rs1),
      .rs2_i    (rs2),
      .rd_i     (rd),
      .flush_i  (flush),
      .stall_o  (stall),
      .busy_o   (busy),
      .valid_o  (valid),
      .result_o (result),
      .rd_o     (rd_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic run_op(input string tag,
                         input logic [2:0] o,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [4:0] r,
                         input logic [31:0] exp,
                         input int exp_lat);
      int lat;
      int st;
      start = 1'b1;
      op    = o;
      rs1   = a;
      rs2   = b;
      rd    = r;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      st  = 0;
      while (!valid && lat < 100) begin
         if (stall) st++;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, " result"}, 64'(result), 64'(exp));
      chk({tag, " rd"}, 64'(rd_out), 64'(r));
      chk({tag, " stall cycles"}, 64'(st), 64'(exp_lat));
      @(posedge clk); #1;
      chk({tag, " pulse"}, 64'(valid), 64'(0));
   endtask

   initial begin
      int cnt;
      #12;
      chk("rst busy", 64'(busy), 64'(0));
      chk("rst valid", 64'(valid), 64'(0));
      chk("rst result", 64'(result), 64'(0));
      chk("rst rd", 64'(rd_out), 64'(0));
      chk("rst stall", 64'(stall), 64'(0));
      rst = 1'b1;
      @(posedge clk); #1;

      start = 1'b1;
      op    = 3'd0;
      #1;
      chk("accept stall", 64'(stall), 64'(1));
      start = 1'b0;

      run_op("mul 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5,
             32'hFFFF_FFEB, 32);
      run_op("mul big", 3'd0, 32'h1234_5678, 32'd9, 5'd3,
             32'hA3D7_0A38, 32);
      run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             5'd7, 32'hFFFF_FFFE, 32);
      run_op("mulh min", 3'd1, 32'h8000_0000, 32'h8000_0000,
             5'd8, 32'h4000_0000, 32);
      run_op("mulh -1*5", 3'd1, 32'hFFFF_FFFF, 32'd5,
             5'd9, 32'hFFFF_FFFF, 32);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             5'd10, 32'hFFFF_FFFF, 32);

      run_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11,
             32'hFFFF_FFFD, 32);
      run_op("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd12,
             32'hFFFF_FFFF, 32);
      run_op("div 7/-2", 3'd4, 32'd7, 32'hFFFF_FFFE, 5'd13,
             32'hFFFF_FFFD, 32);
      run_op("rem 7/-2", 3'd6, 32'd7, 32'hFFFF_FFFE, 5'd14,
             32'd1, 32);
      run_op("divu 100/7", 3'd5, 32'd100, 32'd7, 5'd15,
             32'd14, 32);
      run_op("remu 100/7", 3'd7, 32'd100, 32'd7, 5'd16,
             32'd2, 32);

      run_op("div 5/0", 3'd4, 32'd5, 32'd0, 5'd17,
             32'hFFFF_FFFF, 1);
      run_op("remu 5/0", 3'd7, 32'd5, 32'd0, 5'd18,
             32'd5, 1);
      run_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
             5'd19, 32'h8000_0000, 1);
      run_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF,
             5'd20, 32'd0, 1);

      run_op("mul 0*123", 3'd0, 32'd0, 32'd123, 5'd21,
             32'd0, EO_LAT);
      run_op("divu 3/9", 3'd5, 32'd3, 32'd9, 5'd22,
             32'd0, EO_LAT);
      run_op("remu 3/9", 3'd7, 32'd3, 32'd9, 5'd23,
             32'd3, EO_LAT);
      run_op("rem -3/9", 3'd6, 32'hFFFF_FFFD, 32'd9, 5'd24,
             32'hFFFF_FFFD, EO_LAT);

      // flush at iteration 10
      start = 1'b1;
      op    = 3'd5;
      rs1   = 32'd100;
      rs2   = 32'd7;
      rd    = 5'd25;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      chk("pre-flush busy", 64'(busy), 64'(1));
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush busy", 64'(busy), 64'(0));
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (valid) cnt++;
         @(posedge clk); #1;
      end
      chk("flush no valid", 64'(cnt), 64'(0));
      chk("flush rd kept", 64'(rd_out), 64'(24));

      // start with flush in IDLE
      start = 1'b1;
      flush = 1'b1;
      #1;
      chk("start+flush stall", 64'(stall), 64'(0));
      @(posedge clk); #1;
      start = 1'b0;
      flush = 1'b0;
      chk("start+flush busy", 64'(busy), 64'(0));

      // start while busy is ignored
      start = 1'b1;
      op    = 3'd0;
      rs1   = 32'd7;
      rs2   = 32'hFFFF_FFFD;
      rd    = 5'd5;
      @(posedge clk); #1;
      op    = 3'd5;
      rs1   = 32'd100;
      rs2   = 32'd7;
      rd    = 5'd9;
      repeat (3) begin
         @(posedge clk); #1;
      end
      start = 1'b0;
      cnt = 3;
      while (!valid && cnt < 100) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("ignore lat", 64'(cnt), 64'(32));
      chk("ignore result", 64'(result), 64'hFFFF_FFEB);
      chk("ignore rd", 64'(rd_out), 64'(5));
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("ignore idle", 64'(busy), 64'(0));

      // async reset mid-multiply
      start = 1'b1;
      op    = 3'd0;
      rs1   = 32'd9;
      rs2   = 32'd9;
      rd    = 5'd30;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      chk("pre-rst busy", 64'(busy), 64'(1));
      #1;
      rst = 1'b0;
      #1;
      chk("mid rst busy", 64'(busy), 64'(0));
      chk("mid rst stall", 64'(stall), 64'(0));
      chk("mid rst result", 64'(result), 64'(0));
      chk("mid rst rd", 64'(rd_out), 64'(0));
      chk("mid rst valid", 64'(valid), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (valid) cnt++;
         @(posedge clk); #1;
      end
      chk("post rst no valid", 64'(cnt), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
